sort_out_buf: RTL

- Output stage directly downstream of the SORT block.
- Consumes SORT's DOUT_VLD/DATA_OUT stream, buffers it in a small FIFO and presents it to the next stage over a valid/ready handshake.
- Throttles SORT through DOUT_EN (credit-style) and tracks frame length, overflow and, optionally, sort order.

---
 rtl/sort_out_buf.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sort_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : sort_out_buf
//  Description : Output FIFO stage behind SORT. Credit-style DOUT_EN, frame
//                tracking (OUT_LAST), sticky overflow flag. Optional in-frame
//                ascending-order checker enabled by macro SORT_ORDER_CHK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sort_out_buf #(
    parameter int DATA_W    = 5,
    parameter int DEPTH     = 8,
    parameter int SKID      = 2,
    parameter int FRAME_LEN = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic                     SORT_VLD,
    input  logic [DATA_W-1:0]        SORT_DATA,
    output logic                     DOUT_EN,
    output logic                     OUT_VLD,
    output logic [DATA_W-1:0]        OUT_DATA,
    input  logic                     OUT_RDY,
    output logic                     OUT_LAST,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVF,
    output logic                     ORDER_ERR
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam int c_cw = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [c_lw-1:0] c_depth      = c_lw'(DEPTH);
    localparam logic [c_lw-1:0] c_skid       = c_lw'(SKID);
    localparam logic [c_lw-1:0] c_lvl_one    = c_lw'(1);
    localparam logic [c_aw-1:0] c_ptr_one    = c_aw'(1);
    localparam logic [c_cw-1:0] c_cnt_one    = c_cw'(1);
    localparam logic [c_cw-1:0] c_frame_last = c_cw'(FRAME_LEN - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_last;
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_lw-1:0]   r_level;
    logic [c_cw-1:0]   r_in_cnt;
    logic              r_dout_en;
    logic              r_ovf;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_in_last;
    logic [c_lw-1:0]   w_level_next;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == c_depth);
    assign w_pop     = !w_empty && OUT_RDY;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign w_push    = SORT_VLD && (!w_full || w_pop);
    assign w_drop    = SORT_VLD && w_full && !w_pop;
    assign w_in_last = (r_in_cnt == c_frame_last);

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + c_lvl_one;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - c_lvl_one;
        end
    end

    // Storage carries no reset; the read side is gated by occupancy.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr]  <= SORT_DATA;
            r_last[r_wr_ptr] <= w_in_last;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST || CLR) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_in_cnt  <= '0;
            r_dout_en <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                r_in_cnt <= w_in_last ? '0 : (r_in_cnt + c_cnt_one);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_level   <= w_level_next;
            r_dout_en <= (c_depth - w_level_next) > c_skid;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef SORT_ORDER_CHK_EN
    logic [DATA_W-1:0] r_prev;
    logic              r_first;
    logic              r_order_err;

    always_ff @(posedge CLK) begin
        if (!RST || CLR) begin
            r_prev      <= '0;
            r_first     <= 1'b1;
            r_order_err <= 1'b0;
        end else if (w_push) begin
            if (!r_first && (SORT_DATA < r_prev)) begin
                r_order_err <= 1'b1;
            end
            r_prev  <= SORT_DATA;
            r_first <= w_in_last;
        end
    end

    assign ORDER_ERR = r_order_err;
`else
    assign ORDER_ERR = 1'b0;
`endif

    assign DOUT_EN  = r_dout_en;
    assign OUT_VLD  = !w_empty;
    assign OUT_DATA = w_empty ? '0 : r_mem[r_rd_ptr];
    assign OUT_LAST = !w_empty && r_last[r_rd_ptr];
    assign LEVEL    = r_level;
    assign OVF      = r_ovf;

endmodule
`default_nettype wire
